// File: rtl/counter_readout_pkg.sv
// Shared types and constants for the counter readout transmitter.
// The trailing parity slot is enabled with READOUT_PARITY_EN.
package counter_readout_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic FRAME_N_IDLE = 1'b1;
   localparam logic SCLK_IDLE    = 1'b0;
   localparam logic SDATA_IDLE   = 1'b0;

   // Bits needed to hold the values 0..max_val.
   function automatic int cnt_bits(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/counter_readout_tx_timer.sv
// Bit-slot timer: div_cnt runs 0..2*DIV-1 across one bit slot; the first
// DIV counts are the sclk-low phase and the last DIV counts the high phase.
module readout_bit_timer
   import counter_readout_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic phase,
   output logic bit_end,
   output logic half_end
);

   localparam int DW = cnt_bits(2 * DIV - 1);
   localparam logic [DW-1:0] LAST_CNT   = DW'(2 * DIV - 1);
   localparam logic [DW-1:0] HALF_LAST  = DW'(DIV - 1);
   localparam logic [DW-1:0] HIGH_START = DW'(DIV);

   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_cnt_nxt;

   always_comb begin
      div_cnt_nxt = div_cnt;
      if (clr)
         div_cnt_nxt = '0;
      else if (en)
         div_cnt_nxt = bit_end ? '0 : div_cnt + DW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt_nxt;
   end

   assign bit_end  = (div_cnt == LAST_CNT);
   assign half_end = (div_cnt == HALF_LAST);
   // Level for the coming cycle, so the caller can register sclk directly.
   assign phase    = (div_cnt_nxt >= HIGH_START);

endmodule

// File: rtl/counter_readout_tx.sv
// Serial readout transmitter: snapshots count_in on start and shifts it out
// MSB-first on frame_n/sclk/sdata. READOUT_PARITY_EN adds an even-parity bit.
module counter_readout_tx
   import counter_readout_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             frame_n,
   output logic             sclk,
   output logic             sdata
);

   localparam int BW = cnt_bits(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

`ifdef READOUT_PARITY_EN
   localparam state_t AFTER_LAST = PARITY;
`else
   localparam state_t AFTER_LAST = STOP;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic             tmr_clr, tmr_en;
   logic             phase, bit_end, half_end;
   logic             done_nxt, sclk_nxt, sdata_nxt;

   readout_bit_timer #(.DIV(DIV)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .en       (tmr_en),
      .phase    (phase),
      .bit_end  (bit_end),
      .half_end (half_end)
   );

`ifdef READOUT_PARITY_EN
   // Parity is taken from the snapshot at capture time, not from shreg.
   logic par_q;
   always_ff @(posedge clk) begin
      if (rst)
         par_q <= 1'b0;
      else if (state == IDLE && start)
         par_q <= ^count_in;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            tmr_clr = 1'b1;
            if (start) begin
               state_nxt   = SHIFT;
               shreg_nxt   = count_in;
               bit_cnt_nxt = '0;
            end
         end
         SHIFT: begin
            tmr_en = 1'b1;
            if (bit_end) begin
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = AFTER_LAST;
               end else begin
                  shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
                  bit_cnt_nxt = bit_cnt + BW'(1);
               end
            end
         end
`ifdef READOUT_PARITY_EN
         PARITY: begin
            tmr_en = 1'b1;
            if (bit_end)
               state_nxt = STOP;
         end
`endif
         STOP: begin
            tmr_en = 1'b1;
            if (half_end) begin
               state_nxt = IDLE;
               tmr_clr   = 1'b1;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line levels are derived from the next state so every pin is a flop.
   always_comb begin
      sclk_nxt  = SCLK_IDLE;
      sdata_nxt = SDATA_IDLE;
      case (state_nxt)
         SHIFT: begin
            sclk_nxt  = phase;
            sdata_nxt = shreg_nxt[WIDTH-1];
         end
`ifdef READOUT_PARITY_EN
         PARITY: begin
            sclk_nxt  = phase;
            sdata_nxt = par_q;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         frame_n <= FRAME_N_IDLE;
         sclk    <= SCLK_IDLE;
         sdata   <= SDATA_IDLE;
      end else begin
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
         busy    <= (state_nxt != IDLE);
         done    <= done_nxt;
         frame_n <= (state_nxt == IDLE) ? FRAME_N_IDLE : ~FRAME_N_IDLE;
         sclk    <= sclk_nxt;
         sdata   <= sdata_nxt;
      end
   end

endmodule

// File: tb/tb_counter_readout_tx.sv
// Directed bench for counter_readout_tx (WIDTH=8, DIV=2 plus a DIV=1 copy).
// Expectations follow READOUT_PARITY_EN when it is defined.
module tb_counter_readout_tx;

   localparam int WIDTH = 8;
   localparam int DIV   = 2;
`ifdef READOUT_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int N      = WIDTH + P;
   localparam int FRAME  = 2 * DIV * N + DIV;
   localparam int FRAME1 = 2 * N + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             start1 = 1'b0;
   logic [WIDTH-1:0] count_in = '0;
   logic [WIDTH-1:0] count_in1 = '0;
   logic             busy, done, frame_n, sclk, sdata;
   logic             busy1, done1, frame_n1, sclk1, sdata1;

   int checks = 0;
   int fails  = 0;

   logic [N-1:0] g1, g2;
   int           rises, dcnt, d1, d2, falls, fall2, bc, viol;
   logic         ps, pf;

   counter_readout_tx #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
      .clk(clk), .rst(rst), .count_in(count_in), .start(start),
      .busy(busy), .done(done), .frame_n(frame_n), .sclk(sclk), .sdata(sdata)
   );

   counter_readout_tx #(.WIDTH(WIDTH), .DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .count_in(count_in1), .start(start1),
      .busy(busy1), .done(done1), .frame_n(frame_n1), .sclk(sclk1), .sdata(sdata1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] exp_word(input logic [WIDTH-1:0] v);
`ifdef READOUT_PARITY_EN
      return {v, ^v};
`else
      return v;
`endif
   endfunction

   // One frame on the DIV=2 instance; optionally scramble count_in or poke start mid-frame.
   task automatic run_frame(input string tag, input logic [WIDTH-1:0] val,
                            input logic [N-1:0] exp_bits, input bit scramble, input bit poke);
      logic [N-1:0] got = '0;
      int n_rise = 0, first_low = -1, last_low = -1, done_at = -1, done_n = 0, busy_n = 0, bad = 0;
      logic prev_sclk = 1'b0, prev_sdata = 1'b0;
      count_in = val;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int rel = 1; rel <= FRAME + 4; rel++) begin
         if (!frame_n) begin
            if (first_low < 0) first_low = rel;
            last_low = rel;
         end
         if (done) begin
            done_n++;
            done_at = rel;
         end
         if (busy) busy_n++;
         if (busy !== !frame_n) bad++;
         if (sclk && frame_n) bad++;
         if (sclk && !prev_sclk) begin
            got = {got[N-2:0], sdata};
            n_rise++;
         end
         if (sclk && prev_sclk && sdata !== prev_sdata) bad++;
         prev_sclk  = sclk;
         prev_sdata = sdata;
         if (scramble) count_in = WIDTH'($urandom);
         if (poke) start = (rel == 10 || rel == 20);
         step();
      end
      start = 1'b0;
      check({tag, "_bits"},      got,       exp_bits);
      check({tag, "_rises"},     n_rise,    N);
      check({tag, "_first_low"}, first_low, 1);
      check({tag, "_last_low"},  last_low,  FRAME);
      check({tag, "_done_at"},   done_at,   FRAME + 1);
      check({tag, "_done_cnt"},  done_n,    1);
      check({tag, "_busy_len"},  busy_n,    FRAME);
      check({tag, "_protocol"},  bad,       0);
   endtask

   initial begin
      // Reset held with start asserted: nothing may start.
      rst = 1'b1; start = 1'b1; start1 = 1'b1; count_in = 8'hFF; count_in1 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_hold", {busy, done, frame_n, sclk, sdata}, 5'b00100);
      end
      check("reset_hold_div1", {busy1, done1, frame_n1, sclk1, sdata1}, 5'b00100);
      rst = 1'b0; start = 1'b0; start1 = 1'b0;
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if ({busy, done, frame_n, sclk, sdata} !== 5'b00100) viol++;
         if ({busy1, done1, frame_n1, sclk1, sdata1} !== 5'b00100) viol++;
      end
      check("idle_20", viol, 0);

      // 0xA5 = bits 1,0,1,0,0,1,0,1
      run_frame("basic_a5", 8'hA5, exp_word(8'b1010_0101), 1'b0, 1'b0);
      run_frame("snapshot", 8'hA5, exp_word(8'hA5), 1'b1, 1'b0);
      run_frame("ignore_start", 8'h6E, exp_word(8'h6E), 1'b0, 1'b1);
      run_frame("all_ones", 8'hFF, exp_word(8'hFF), 1'b0, 1'b0);
      run_frame("all_zeros", 8'h00, exp_word(8'h00), 1'b0, 1'b0);

`ifdef READOUT_PARITY_EN
      // 0x07 has three ones -> parity 1; 0xA5 has four ones -> parity 0.
      run_frame("parity_07", 8'h07, 9'b0_0000_1111, 1'b0, 1'b0);
      run_frame("parity_a5", 8'hA5, 9'b1_0100_1010, 1'b0, 1'b0);
`endif

      // start held high: second frame starts the cycle after done, capturing the new value.
      count_in = 8'h3C; start = 1'b1;
      step();
      g1 = '0; g2 = '0; rises = 0; dcnt = 0; d1 = -1; d2 = -1; falls = 0; fall2 = -1;
      ps = 1'b0; pf = 1'b1;
      for (int rel = 1; rel <= 2 * (FRAME + 1) + 2; rel++) begin
         if (pf && !frame_n) begin
            falls++;
            if (falls == 2) fall2 = rel;
         end
         if (done) begin
            dcnt++;
            if (dcnt == 1) d1 = rel;
            else d2 = rel;
         end
         if (sclk && !ps) begin
            if (rises < N) g1 = {g1[N-2:0], sdata};
            else g2 = {g2[N-2:0], sdata};
            rises++;
         end
         ps = sclk;
         pf = frame_n;
         if (rel == 5) count_in = 8'hC3;
         if (rel == 40) start = 1'b0;
         step();
      end
      start = 1'b0;
      check("b2b_done1",  d1,    FRAME + 1);
      check("b2b_fall2",  fall2, FRAME + 2);
      check("b2b_done2",  d2,    2 * (FRAME + 1));
      check("b2b_dcnt",   dcnt,  2);
      check("b2b_frame1", g1,    exp_word(8'h3C));
      check("b2b_frame2", g2,    exp_word(8'hC3));

      // Reset in the middle of a frame abandons it with no done pulse.
      count_in = 8'h81; start = 1'b1;
      step();
      start = 1'b0;
      for (int rel = 1; rel < 10; rel++) step();
      check("midrst_in_frame", frame_n, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_outputs", {busy, done, frame_n, sclk, sdata}, 5'b00100);
      viol = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || !frame_n || busy) viol++;
         step();
      end
      check("midrst_quiet", viol, 0);
      run_frame("after_rst", 8'h5A, exp_word(8'h5A), 1'b0, 1'b0);

      // DIV=1 instance: sclk toggles every cycle.
      count_in1 = 8'h96; start1 = 1'b1;
      step();
      start1 = 1'b0;
      g1 = '0; rises = 0; d1 = -1; bc = 0; ps = 1'b0;
      for (int rel = 1; rel <= FRAME1 + 4; rel++) begin
         if (sclk1 && !ps) begin
            g1 = {g1[N-2:0], sdata1};
            rises++;
         end
         if (done1) d1 = rel;
         if (busy1) bc++;
         ps = sclk1;
         step();
      end
      check("div1_bits",    g1,    exp_word(8'h96));
      check("div1_rises",   rises, N);
      check("div1_done_at", d1,    FRAME1 + 1);
      check("div1_busy",    bc,    FRAME1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
